conv_window_controller: RTL and testbench
=========================================

# conv_window_controller

Parametrised control FSM for the convolution datapath, driving filter load, sliding-window input fetch, MAC accumulation and result write-back. It generalises the fixed filter/input/table sequence to a K×K filter over an IMG_W×IMG_H image. It adds a start/busy/done handshake and a hold (stall) input. It sits between the shared data memory and the MAC/accumulator/output-memory datapath.

## Interface
- K, 3, filter side length (K ≥ 2)
- IMG_W, 8, image width in pixels (IMG_W ≥ K)
- IMG_H, 8, image height in pixels (IMG_H ≥ K)
- IMG_BASE, 16, memory address of image pixel (0,0); filter occupies addresses 0..K*K-1
- ADDR_W, 10, address width; IMG_BASE+IMG_W*IMG_H ≤ 2^ADDR_W
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  begin a convolution; sampled only in IDLE
- hold  in  1  stall; freezes FLOAD and MAC
- memAddr  out  ADDR_W  data-memory read address
- memRdEn  out  1  data-memory read enable
- memInSel  out  2  datapath source select: 01 filter, 00 image, 10 output path
- filterLd  out  1  write memory data into filter register filterIdx
- filterIdx  out  clog2(K*K)  filter register index (load and MAC)
- inputLd  out  1  latch memory data as current pixel
- macEn  out  1  accumulate pixel × filter[filterIdx]
- accClr  out  1  clear accumulator
- outWrEn  out  1  write accumulator to output memory
- outAddr  out  ADDR_W  output-memory address
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse

## Operation
- Derived values: OW = IMG_W-K+1, OH = IMG_H-K+1. Counters: fcnt, kx, ky, col, row.
- All outputs are combinational from the state and counters. Outputs not listed for a state are 0.
- IDLE: busy=0 and memAddr=0. When start=1, load fcnt=kx=ky=col=row=0 and go to FLOAD.
- FLOAD:
  - Outputs: memRdEn=1, memInSel=01, memAddr=fcnt, filterLd=1, filterIdx=fcnt.
  - fcnt increments each cycle. After fcnt=K*K-1, go to CLEAR.
- CLEAR: accClr=1 for one cycle, then go to MAC.
- MAC:
  - Outputs: memRdEn=1, memInSel=00, memAddr=IMG_BASE+(row+ky)*IMG_W+(col+kx), inputLd=1, macEn=1, filterIdx=ky*K+kx.
  - kx increments. At kx=K-1, kx wraps to 0 and ky increments.
  - At kx=ky=K-1, ky wraps to 0 and the state goes to WRITE.
- WRITE:
  - Outputs: outWrEn=1, memInSel=10, outAddr=row*OW+col.
  - col increments. At col=OW-1, col wraps to 0 and row increments.
  - If row=OH-1 and col=OW-1, go to DONE; otherwise go to CLEAR.
- DONE: done=1 for one cycle, then go to IDLE.
- hold=1 in FLOAD or MAC:
  - State and all counters are frozen.
  - memRdEn, filterLd, inputLd and macEn are forced to 0; memAddr keeps its value.
  - hold is ignored in all other states.
- start is ignored while busy=1, including in DONE.
- Address arithmetic is unsigned, computed at ≥ ADDR_W+1 bits and truncated to ADDR_W bits. The parameter constraint guarantees no truncation occurs.
- Reset (rst=0, any time):
  - State goes to IDLE and all counters clear immediately, without waiting for clk.
  - All outputs go to 0: busy=0, done=0, memAddr=0, outAddr=0.
  - No partial write is issued.

## Timing
- Memory read is combinational: data for memAddr is valid in the same cycle. filterLd and inputLd/macEn use it at the next rising edge.
- Let E0 be the edge that samples start=1. FLOAD occupies cycles 0..K*K-1 after E0.
- Each output position takes K*K+2 cycles: CLEAR + K*K MAC + WRITE.
- done is high in cycle K*K + OW*OH*(K*K+2) after E0, plus the number of hold cycles in FLOAD/MAC. For defaults: 405.
- busy rises in the cycle after E0. busy falls together with done, i.e. in the IDLE cycle after DONE.
- Back-to-back runs: start held high on the IDLE cycle after DONE begins a new run immediately.

## Test plan
- Reset: assert rst=0 mid-clock. Required: all outputs 0 immediately. Release, run no start for 5 cycles: busy=0, memRdEn=0.
- Default full run (K=3, 8×8):
  - Filter phase: memAddr 0..8 with filterLd.
  - First MAC phase: memAddr 16,17,18,24,25,26,32,33,34.
  - Write phase: 36 outWrEn pulses, outAddr 0..35 in order.
  - done exactly at cycle 405 after E0, single cycle.
- Hold: hold=1 for 3 cycles in the 5th MAC cycle of position 0. Required:
  - memAddr stays 25, macEn=0 during hold.
  - Sequence resumes at 25, then 26.
  - done at cycle 408.
- Start while busy: pulse start at cycles 50 and 405. Required: no restart, counters unaffected, done still at 405.
- Reset mid-run: rst=0 at cycle 120 (MAC). Required: busy=0 immediately. A new start restarts with memAddr 0, filterLd=1.
- Parameter variant K=2, IMG_W=IMG_H=4, IMG_BASE=8:
  - OW=OH=3, 9 outWrEn pulses with outAddr 0..8.
  - Last MAC addresses 18,19,22,23.
  - done at cycle 4+9*6=58.

Source files
------------

// File: rtl/conv_window_controller.sv
// Control FSM for a K x K sliding-window convolution: filter load, window fetch,
// MAC accumulation and result write-back, with start/busy/done handshake and hold stall.
module conv_window_controller #(
    parameter int unsigned K        = 3,
    parameter int unsigned IMG_W    = 8,
    parameter int unsigned IMG_H    = 8,
    parameter int unsigned IMG_BASE = 16,
    parameter int unsigned ADDR_W   = 10,
    localparam int unsigned FI_W    = $clog2(K * K)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              hold,
    output logic [ADDR_W-1:0] memAddr,
    output logic              memRdEn,
    output logic [1:0]        memInSel,
    output logic              filterLd,
    output logic [FI_W-1:0]   filterIdx,
    output logic              inputLd,
    output logic              macEn,
    output logic              accClr,
    output logic              outWrEn,
    output logic [ADDR_W-1:0] outAddr,
    output logic              busy,
    output logic              done
);

    localparam int unsigned NF  = K * K;
    localparam int unsigned OW  = IMG_W - K + 1;
    localparam int unsigned OH  = IMG_H - K + 1;
    localparam int unsigned KW  = (K > 1) ? $clog2(K) : 1;
    localparam int unsigned CW  = (OW > 1) ? $clog2(OW) : 1;
    localparam int unsigned RW  = (OH > 1) ? $clog2(OH) : 1;
    localparam int unsigned AW1 = ADDR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FLOAD,
        S_CLEAR,
        S_MAC,
        S_WRITE,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [FI_W-1:0] fcnt_q, fcnt_d;
    logic [KW-1:0]   kx_q, kx_d;
    logic [KW-1:0]   ky_q, ky_d;
    logic [CW-1:0]   col_q, col_d;
    logic [RW-1:0]   row_q, row_d;

    // State and counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            fcnt_q  <= '0;
            kx_q    <= '0;
            ky_q    <= '0;
            col_q   <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            kx_q    <= kx_d;
            ky_q    <= ky_d;
            col_q   <= col_d;
            row_q   <= row_d;
        end
    end

    // Next-state and counter sequencing; hold freezes FLOAD and MAC only
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        kx_d    = kx_q;
        ky_d    = ky_q;
        col_d   = col_q;
        row_d   = row_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    fcnt_d  = '0;
                    kx_d    = '0;
                    ky_d    = '0;
                    col_d   = '0;
                    row_d   = '0;
                    state_d = S_FLOAD;
                end
            end
            S_FLOAD: begin
                if (!hold) begin
                    if (fcnt_q == FI_W'(NF - 1)) begin
                        fcnt_d  = '0;
                        state_d = S_CLEAR;
                    end else begin
                        fcnt_d = fcnt_q + FI_W'(1);
                    end
                end
            end
            S_CLEAR: state_d = S_MAC;
            S_MAC: begin
                if (!hold) begin
                    if (kx_q == KW'(K - 1)) begin
                        kx_d = '0;
                        if (ky_q == KW'(K - 1)) begin
                            ky_d    = '0;
                            state_d = S_WRITE;
                        end else begin
                            ky_d = ky_q + KW'(1);
                        end
                    end else begin
                        kx_d = kx_q + KW'(1);
                    end
                end
            end
            S_WRITE: begin
                state_d = S_CLEAR;
                if (col_q == CW'(OW - 1)) begin
                    col_d = '0;
                    if (row_q == RW'(OH - 1)) begin
                        row_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        row_d = row_q + RW'(1);
                    end
                end else begin
                    col_d = col_q + CW'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decode straight from state and counters so memory reads see the address this cycle
    always_comb begin
        memAddr   = '0;
        memRdEn   = 1'b0;
        memInSel  = 2'b00;
        filterLd  = 1'b0;
        filterIdx = '0;
        inputLd   = 1'b0;
        macEn     = 1'b0;
        accClr    = 1'b0;
        outWrEn   = 1'b0;
        outAddr   = '0;
        busy      = (state_q != S_IDLE);
        done      = 1'b0;
        case (state_q)
            S_FLOAD: begin
                memAddr   = ADDR_W'(fcnt_q);
                memRdEn   = !hold;
                memInSel  = 2'b01;
                filterLd  = !hold;
                filterIdx = fcnt_q;
            end
            S_CLEAR: accClr = 1'b1;
            S_MAC: begin
                memAddr   = ADDR_W'(AW1'(IMG_BASE)
                                    + (AW1'(row_q) + AW1'(ky_q)) * AW1'(IMG_W)
                                    + AW1'(col_q) + AW1'(kx_q));
                memRdEn   = !hold;
                memInSel  = 2'b00;
                inputLd   = !hold;
                macEn     = !hold;
                filterIdx = FI_W'(ky_q) * FI_W'(K) + FI_W'(kx_q);
            end
            S_WRITE: begin
                outWrEn  = 1'b1;
                memInSel = 2'b10;
                outAddr  = ADDR_W'(AW1'(row_q) * AW1'(OW) + AW1'(col_q));
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_conv_window_controller.sv
// Scoreboard bench for conv_window_controller: default 3x3/8x8 instance and a 2x2/4x4 variant.
module tb_conv_window_controller;

    typedef struct packed {
        logic [9:0] mem_addr;
        logic       mem_rd_en;
        logic [1:0] mem_in_sel;
        logic       filter_ld;
        logic [3:0] filter_idx;
        logic       input_ld;
        logic       mac_en;
        logic       acc_clr;
        logic       out_wr_en;
        logic [9:0] out_addr;
        logic       busy;
        logic       done;
    } obs_t;

    typedef struct {
        int inst;
        int kind;
        int addr;
        int idx;
        int cyc;
    } ev_t;

    localparam int K_F = 0, K_C = 1, K_M = 2, K_W = 3, K_D = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start0 = 1'b0, hold0 = 1'b0, start1 = 1'b0, hold1 = 1'b0;

    logic [9:0] m0_addr, m0_oaddr, m1_addr, m1_oaddr;
    logic [1:0] m0_sel, m1_sel;
    logic [3:0] m0_fidx;
    logic [1:0] m1_fidx;
    logic m0_rd, m0_fld, m0_ild, m0_mac, m0_clr, m0_wr, m0_busy, m0_done;
    logic m1_rd, m1_fld, m1_ild, m1_mac, m1_clr, m1_wr, m1_busy, m1_done;

    obs_t obs [2];
    ev_t  exp_q[$];
    ev_t  plan_q[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    conv_window_controller dut0 (
        .clk(clk), .rst(rst), .start(start0), .hold(hold0),
        .memAddr(m0_addr), .memRdEn(m0_rd), .memInSel(m0_sel), .filterLd(m0_fld),
        .filterIdx(m0_fidx), .inputLd(m0_ild), .macEn(m0_mac), .accClr(m0_clr),
        .outWrEn(m0_wr), .outAddr(m0_oaddr), .busy(m0_busy), .done(m0_done)
    );

    conv_window_controller #(
        .K(2), .IMG_W(4), .IMG_H(4), .IMG_BASE(8), .ADDR_W(10)
    ) dut1 (
        .clk(clk), .rst(rst), .start(start1), .hold(hold1),
        .memAddr(m1_addr), .memRdEn(m1_rd), .memInSel(m1_sel), .filterLd(m1_fld),
        .filterIdx(m1_fidx), .inputLd(m1_ild), .macEn(m1_mac), .accClr(m1_clr),
        .outWrEn(m1_wr), .outAddr(m1_oaddr), .busy(m1_busy), .done(m1_done)
    );

    assign obs[0] = {m0_addr, m0_rd, m0_sel, m0_fld, m0_fidx, m0_ild, m0_mac,
                     m0_clr, m0_wr, m0_oaddr, m0_busy, m0_done};
    assign obs[1] = {m1_addr, m1_rd, m1_sel, m1_fld, {2'b00, m1_fidx}, m1_ild, m1_mac,
                     m1_clr, m1_wr, m1_oaddr, m1_busy, m1_done};

    // Expected output vector for one reference event
    function automatic obs_t exp_obs(input ev_t e);
        obs_t o;
        o = '0;
        o.busy = 1'b1;
        case (e.kind)
            K_F: begin
                o.mem_addr = 10'(e.addr); o.mem_rd_en = 1'b1; o.mem_in_sel = 2'b01;
                o.filter_ld = 1'b1; o.filter_idx = 4'(e.idx);
            end
            K_C: o.acc_clr = 1'b1;
            K_M: begin
                o.mem_addr = 10'(e.addr); o.mem_rd_en = 1'b1; o.mem_in_sel = 2'b00;
                o.input_ld = 1'b1; o.mac_en = 1'b1; o.filter_idx = 4'(e.idx);
            end
            K_W: begin
                o.out_wr_en = 1'b1; o.mem_in_sel = 2'b10; o.out_addr = 10'(e.addr);
            end
            default: o.done = 1'b1;
        endcase
        return o;
    endfunction

    function automatic bit presents(input obs_t o);
        return o.mem_rd_en | o.filter_ld | o.input_ld | o.mac_en | o.acc_clr | o.out_wr_en | o.done;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, expv);
        end
    endtask

    // Reference: one cycle per phase of a run, derived from image geometry alone
    task automatic build_plan(input int inst);
        int k, w, h, base, ow, oh;
        ev_t e;
        k = (inst == 0) ? 3 : 2;
        w = (inst == 0) ? 8 : 4;
        h = w;
        base = (inst == 0) ? 16 : 8;
        ow = w - k + 1;
        oh = h - k + 1;
        plan_q.delete();
        e.inst = inst; e.cyc = 0;
        for (int f = 0; f < k * k; f++) begin
            e.kind = K_F; e.addr = f; e.idx = f; plan_q.push_back(e);
        end
        for (int r = 0; r < oh; r++)
            for (int c = 0; c < ow; c++) begin
                e.kind = K_C; e.addr = 0; e.idx = 0; plan_q.push_back(e);
                for (int ky = 0; ky < k; ky++)
                    for (int kx = 0; kx < k; kx++) begin
                        e.kind = K_M; e.addr = base + (r + ky) * w + c + kx; e.idx = ky * k + kx;
                        plan_q.push_back(e);
                    end
                e.kind = K_W; e.addr = r * ow + c; e.idx = 0; plan_q.push_back(e);
            end
        e.kind = K_D; e.addr = 0; e.idx = 0; plan_q.push_back(e);
    endtask

    task automatic drive(input int inst, input logic s, input logic h);
        if (inst == 0) begin start0 = s; hold0 = h; end
        else begin start1 = s; hold1 = h; end
    endtask

    function automatic bit holdable(input int kind);
        return (kind == K_F) || (kind == K_M);
    endfunction

    // hmode: 0 none, 1 three cycles from cycle 14, 2 random; smode: 0 none, 1 cycles 50/405, 2 random
    task automatic run(input int inst, input int hmode, input int smode, input int abort_n);
        bit   hp[$];
        bit   h;
        int   ptr, n, c0;
        ev_t  e;
        obs_t xo;
        build_plan(inst);
        c0 = cyc + 1;
        ptr = 0;
        n = 0;
        while (ptr < plan_q.size()) begin
            case (hmode)
                1:       h = (n >= 14 && n <= 16);
                2:       h = ($urandom_range(3) == 0);
                default: h = 1'b0;
            endcase
            hp.push_back(h);
            if (!(h && holdable(plan_q[ptr].kind))) begin
                e = plan_q[ptr];
                e.cyc = c0 + n;
                exp_q.push_back(e);
                ptr++;
            end
            n++;
        end
        drive(inst, 1'b1, 1'b0);
        @(posedge clk); #1;
        ptr = 0;
        for (int i = 0; i < hp.size(); i++) begin
            if (i == abort_n) begin
                drive(inst, 1'b0, 1'b0);
                #2 rst = 1'b0;
                #1;
                chk("reset_mid_run_dut0", 64'(obs[0]), 64'(0));
                chk("reset_mid_run_dut1", 64'(obs[1]), 64'(0));
                exp_q.delete();
                @(posedge clk); #3 rst = 1'b1;
                @(posedge clk); #1;
                return;
            end
            case (smode)
                1:       drive(inst, (i == 50 || i == 405), hp[i]);
                2:       drive(inst, ($urandom_range(15) == 0), hp[i]);
                default: drive(inst, 1'b0, hp[i]);
            endcase
            if (hp[i] && holdable(plan_q[ptr].kind)) begin
                #1;
                xo = exp_obs(plan_q[ptr]);
                xo.mem_rd_en = 1'b0; xo.filter_ld = 1'b0; xo.input_ld = 1'b0; xo.mac_en = 1'b0;
                chk("hold_freeze", 64'(obs[inst]), 64'(xo));
            end else begin
                ptr++;
            end
            @(posedge clk); #1;
        end
        drive(inst, 1'b0, 1'b0);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        chk("idle_after_done", {62'(0), obs[inst].busy, obs[inst].done}, 64'(0));
    endtask

    // Monitor: pop and compare whenever an instance presents any activity
    always @(negedge clk) begin
        ev_t e;
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                if (presents(obs[i])) begin
                    n_tests++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_output inst=%0d cyc=%0d got=%h", i, cyc, obs[i]);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.inst != i || e.cyc != cyc || obs[i] !== exp_obs(e)) begin
                            n_fail++;
                            $display("FAIL scoreboard inst=%0d cyc=%0d got=%h exp=%h exp_inst=%0d exp_cyc=%0d",
                                     i, cyc, obs[i], exp_obs(e), e.inst, e.cyc);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #2 rst = 1'b0;
        #1;
        chk("reset_outputs_dut0", 64'(obs[0]), 64'(0));
        chk("reset_outputs_dut1", 64'(obs[1]), 64'(0));
        #20 rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("idle_no_start", {62'(0), obs[0].busy, obs[0].mem_rd_en}, 64'(0));
        end
        run(0, 0, 0, -1);
        run(0, 1, 0, -1);
        run(0, 0, 1, -1);
        repeat (2) @(posedge clk);
        #1;
        run(0, 0, 0, 120);
        run(0, 0, 0, -1);
        run(0, 2, 2, -1);
        run(0, 2, 2, -1);
        run(1, 0, 0, -1);
        run(1, 2, 2, -1);
        run(1, 2, 0, 30);
        run(1, 2, 2, -1);
        run(1, 0, 2, -1);
        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
